polygon_pixel_tester: RTL and testbench

POLYGON_PIXEL_TESTER -- requirements
Module: polygon_pixel_tester

---
 rtl/polygon_pixel_tester.sv | 218 +++++++++++++++++++++
 tb/tb_polygon_pixel_tester.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/polygon_pixel_tester.sv
// Polygon pixel tester: three-stage pipeline deciding whether a screen pixel
// lies inside (or on the boundary of) a square or a triangle.
//   stage 1 : vertex/pixel differences and square bound flags
//   stage 2 : triangle edge functions E1..E3 (exact, no truncation)
//   stage 3 : hit decision, qualified by the bubble bit
// One pixel is accepted every cycle; there is no stall path.
module polygon_pixel_tester (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_bubble,
   input  logic [8:0] in_color,
   input  logic [9:0] in_pixel_x,
   input  logic [9:0] in_pixel_y,
   input  logic       in_form,
   input  logic [9:0] v1_x,
   input  logic [9:0] v1_y,
   input  logic [9:0] v2_x,
   input  logic [9:0] v2_y,
   input  logic [9:0] v3_x,
   input  logic [9:0] v3_y,
   input  logic [9:0] v4_x,
   input  logic [9:0] v4_y,
   output logic       out_hit,
   output logic [8:0] out_color,
   output logic [9:0] out_pixel_x,
   output logic [9:0] out_pixel_y,
   output logic       out_bubble
);

   // Fixed pipeline depth, for reference by integrators only.
   localparam int LATENCY = 3;

   // ---------------------------------------------------------------------
   // Stage 1 combinational: 11-bit signed differences of zero-extended
   // 10-bit operands. 11 bits hold -1023..+1023 exactly.
   // ---------------------------------------------------------------------
   logic signed [10:0] c1_dx1, c1_dx2, c1_dx3;
   logic signed [10:0] c1_dy1, c1_dy2, c1_dy3;
   logic signed [10:0] c1_dpx1, c1_dpx2, c1_dpx3;
   logic signed [10:0] c1_dpy1, c1_dpy2, c1_dpy3;
   logic               c1_ge_left, c1_le_right, c1_ge_top, c1_le_bottom;

   // Difference and bound-flag datapath feeding stage 1.
   always_comb begin
      c1_dx1  = $signed({1'b0, v2_x}) - $signed({1'b0, v1_x});
      c1_dx2  = $signed({1'b0, v3_x}) - $signed({1'b0, v2_x});
      c1_dx3  = $signed({1'b0, v1_x}) - $signed({1'b0, v3_x});
      c1_dy1  = $signed({1'b0, v2_y}) - $signed({1'b0, v1_y});
      c1_dy2  = $signed({1'b0, v3_y}) - $signed({1'b0, v2_y});
      c1_dy3  = $signed({1'b0, v1_y}) - $signed({1'b0, v3_y});
      c1_dpx1 = $signed({1'b0, in_pixel_x}) - $signed({1'b0, v1_x});
      c1_dpx2 = $signed({1'b0, in_pixel_x}) - $signed({1'b0, v2_x});
      c1_dpx3 = $signed({1'b0, in_pixel_x}) - $signed({1'b0, v3_x});
      c1_dpy1 = $signed({1'b0, in_pixel_y}) - $signed({1'b0, v1_y});
      c1_dpy2 = $signed({1'b0, in_pixel_y}) - $signed({1'b0, v2_y});
      c1_dpy3 = $signed({1'b0, in_pixel_y}) - $signed({1'b0, v3_y});
      // Square is axis aligned: left edge from v2, right from v3,
      // top from v1, bottom from v2. v4 is redundant and unused.
      c1_ge_left   = (in_pixel_x >= v2_x);
      c1_le_right  = (in_pixel_x <= v3_x);
      c1_ge_top    = (in_pixel_y >= v1_y);
      c1_le_bottom = (in_pixel_y <= v2_y);
   end

   // Stage 1 registers.
   logic signed [10:0] s1_dx1, s1_dx2, s1_dx3;
   logic signed [10:0] s1_dy1, s1_dy2, s1_dy3;
   logic signed [10:0] s1_dpx1, s1_dpx2, s1_dpx3;
   logic signed [10:0] s1_dpy1, s1_dpy2, s1_dpy3;
   logic               s1_sq_in;
   logic               s1_form;
   logic               s1_bubble;
   logic [8:0]         s1_color;
   logic [9:0]         s1_pixel_x, s1_pixel_y;

   // Capture differences and sideband for the pixel sampled this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_dx1     <= '0;
         s1_dx2     <= '0;
         s1_dx3     <= '0;
         s1_dy1     <= '0;
         s1_dy2     <= '0;
         s1_dy3     <= '0;
         s1_dpx1    <= '0;
         s1_dpx2    <= '0;
         s1_dpx3    <= '0;
         s1_dpy1    <= '0;
         s1_dpy2    <= '0;
         s1_dpy3    <= '0;
         s1_sq_in   <= 1'b0;
         s1_form    <= 1'b0;
         s1_bubble  <= 1'b1;
         s1_color   <= '0;
         s1_pixel_x <= '0;
         s1_pixel_y <= '0;
      end else begin
         s1_dx1     <= c1_dx1;
         s1_dx2     <= c1_dx2;
         s1_dx3     <= c1_dx3;
         s1_dy1     <= c1_dy1;
         s1_dy2     <= c1_dy2;
         s1_dy3     <= c1_dy3;
         s1_dpx1    <= c1_dpx1;
         s1_dpx2    <= c1_dpx2;
         s1_dpx3    <= c1_dpx3;
         s1_dpy1    <= c1_dpy1;
         s1_dpy2    <= c1_dpy2;
         s1_dpy3    <= c1_dpy3;
         s1_sq_in   <= c1_ge_left & c1_le_right & c1_ge_top & c1_le_bottom;
         s1_form    <= in_form;
         s1_bubble  <= in_bubble;
         s1_color   <= in_color;
         s1_pixel_x <= in_pixel_x;
         s1_pixel_y <= in_pixel_y;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 combinational: Ek = dx_k*dpy_k - dy_k*dpx_k.
   // Operands are sign-extended to 22 bits before multiplying so the
   // product is computed at full width; |product| <= 1023*1023 fits.
   // The 23-bit difference cannot overflow.
   // ---------------------------------------------------------------------
   logic signed [21:0] c2_pa1, c2_pa2, c2_pa3;
   logic signed [21:0] c2_pb1, c2_pb2, c2_pb3;
   logic signed [22:0] c2_e1, c2_e2, c2_e3;

   // Edge-function products and differences.
   always_comb begin
      c2_pa1 = $signed({{11{s1_dx1[10]}}, s1_dx1}) * $signed({{11{s1_dpy1[10]}}, s1_dpy1});
      c2_pa2 = $signed({{11{s1_dx2[10]}}, s1_dx2}) * $signed({{11{s1_dpy2[10]}}, s1_dpy2});
      c2_pa3 = $signed({{11{s1_dx3[10]}}, s1_dx3}) * $signed({{11{s1_dpy3[10]}}, s1_dpy3});
      c2_pb1 = $signed({{11{s1_dy1[10]}}, s1_dy1}) * $signed({{11{s1_dpx1[10]}}, s1_dpx1});
      c2_pb2 = $signed({{11{s1_dy2[10]}}, s1_dy2}) * $signed({{11{s1_dpx2[10]}}, s1_dpx2});
      c2_pb3 = $signed({{11{s1_dy3[10]}}, s1_dy3}) * $signed({{11{s1_dpx3[10]}}, s1_dpx3});
      c2_e1  = $signed({c2_pa1[21], c2_pa1}) - $signed({c2_pb1[21], c2_pb1});
      c2_e2  = $signed({c2_pa2[21], c2_pa2}) - $signed({c2_pb2[21], c2_pb2});
      c2_e3  = $signed({c2_pa3[21], c2_pa3}) - $signed({c2_pb3[21], c2_pb3});
   end

   // Stage 2 registers.
   logic signed [22:0] s2_e1, s2_e2, s2_e3;
   logic               s2_sq_in;
   logic               s2_form;
   logic               s2_bubble;
   logic [8:0]         s2_color;
   logic [9:0]         s2_pixel_x, s2_pixel_y;

   // Capture edge functions; form and sideband travel with the pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_e1      <= '0;
         s2_e2      <= '0;
         s2_e3      <= '0;
         s2_sq_in   <= 1'b0;
         s2_form    <= 1'b0;
         s2_bubble  <= 1'b1;
         s2_color   <= '0;
         s2_pixel_x <= '0;
         s2_pixel_y <= '0;
      end else begin
         s2_e1      <= c2_e1;
         s2_e2      <= c2_e2;
         s2_e3      <= c2_e3;
         s2_sq_in   <= s1_sq_in;
         s2_form    <= s1_form;
         s2_bubble  <= s1_bubble;
         s2_color   <= s1_color;
         s2_pixel_x <= s1_pixel_x;
         s2_pixel_y <= s1_pixel_y;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 3 combinational: inside test. Zero counts on both sides, so
   // boundary pixels and degenerate triangles (all Ek = 0 on the line)
   // are hits without any special casing. Winding order is free.
   // ---------------------------------------------------------------------
   logic c3_e1_zero, c3_e2_zero, c3_e3_zero;
   logic c3_all_nonneg, c3_all_nonpos;
   logic c3_tri_in;
   logic c3_hit;

   // Hit decision for the pixel in stage 2.
   always_comb begin
      c3_e1_zero    = (s2_e1 == 23'sd0);
      c3_e2_zero    = (s2_e2 == 23'sd0);
      c3_e3_zero    = (s2_e3 == 23'sd0);
      c3_all_nonneg = !s2_e1[22] && !s2_e2[22] && !s2_e3[22];
      c3_all_nonpos = (s2_e1[22] || c3_e1_zero) &&
                      (s2_e2[22] || c3_e2_zero) &&
                      (s2_e3[22] || c3_e3_zero);
      c3_tri_in     = c3_all_nonneg || c3_all_nonpos;
      c3_hit        = s2_form ? c3_tri_in : s2_sq_in;
      if (s2_bubble) begin
         c3_hit = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_hit     <= 1'b0;
         out_color   <= '0;
         out_pixel_x <= '0;
         out_pixel_y <= '0;
         out_bubble  <= 1'b1;
      end else begin
         out_hit     <= c3_hit;
         out_color   <= s2_color;
         out_pixel_x <= s2_pixel_x;
         out_pixel_y <= s2_pixel_y;
         out_bubble  <= s2_bubble;
      end
   end

endmodule

// File: tb/tb_polygon_pixel_tester.sv
// Directed bench for polygon_pixel_tester: a table of pixels streamed
// back-to-back with hand-computed hits, plus reset sequences.
module tb_polygon_pixel_tester;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_bubble;
   logic [8:0] in_color;
   logic [9:0] in_pixel_x, in_pixel_y;
   logic       in_form;
   logic [9:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, v4_x, v4_y;
   logic       out_hit;
   logic [8:0] out_color;
   logic [9:0] out_pixel_x, out_pixel_y;
   logic       out_bubble;

   int checks = 0;
   int errors = 0;

   polygon_pixel_tester dut (
      .clk(clk), .reset(reset),
      .in_bubble(in_bubble), .in_color(in_color),
      .in_pixel_x(in_pixel_x), .in_pixel_y(in_pixel_y), .in_form(in_form),
      .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
      .v3_x(v3_x), .v3_y(v3_y), .v4_x(v4_x), .v4_y(v4_y),
      .out_hit(out_hit), .out_color(out_color),
      .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
      .out_bubble(out_bubble)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       form;
      logic       bub;
      logic [8:0] col;
      logic [9:0] px;
      logic [9:0] py;
      int         vs;
      logic       hit;
   } vec_t;

   vec_t       vt[32];
   int         nv = 0;
   // vertex sets: 0 square, 1 triangle, 2 disabled, 3 degenerate, 4 full range
   logic [9:0] vx[5][4];
   logic [9:0] vy[5][4];

   task automatic add(input logic form, input logic bub, input logic [8:0] col,
                      input int px, input int py, input int vs, input logic hit);
      vt[nv].form = form;
      vt[nv].bub  = bub;
      vt[nv].col  = col;
      vt[nv].px   = px[9:0];
      vt[nv].py   = py[9:0];
      vt[nv].vs   = vs;
      vt[nv].hit  = hit;
      nv++;
   endtask

   task automatic set_vs(input int s, input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int x4, input int y4);
      vx[s][0] = x1[9:0]; vy[s][0] = y1[9:0];
      vx[s][1] = x2[9:0]; vy[s][1] = y2[9:0];
      vx[s][2] = x3[9:0]; vy[s][2] = y3[9:0];
      vx[s][3] = x4[9:0]; vy[s][3] = y4[9:0];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_pix(input logic form, input logic bub, input logic [8:0] col,
                            input logic [9:0] px, input logic [9:0] py, input int vs);
      in_form    = form;
      in_bubble  = bub;
      in_color   = col;
      in_pixel_x = px;
      in_pixel_y = py;
      v1_x = vx[vs][0]; v1_y = vy[vs][0];
      v2_x = vx[vs][1]; v2_y = vy[vs][1];
      v3_x = vx[vs][2]; v3_y = vy[vs][2];
      v4_x = vx[vs][3]; v4_y = vy[vs][3];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      set_vs(0, 90, 90, 90, 110, 110, 110, 110, 90);
      set_vs(1, 200, 180, 180, 220, 220, 220, 999, 999);
      set_vs(2, 700, 500, 700, 510, 740, 510, 740, 500);
      set_vs(3, 50, 50, 60, 60, 70, 70, 0, 0);
      set_vs(4, 1023, 0, 0, 1023, 1023, 1023, 0, 0);

      //   form bub color   px    py    vs hit
      add(0, 1, 9'h1C7, 100, 100, 0, 0);
      add(0, 0, 9'h1C7, 100, 100, 0, 1);
      add(1, 0, 9'h038, 200, 210, 1, 1);
      add(0, 0, 9'h007, 90, 90, 0, 1);
      add(1, 0, 9'h1FF, 182, 182, 1, 0);
      add(0, 0, 9'h155, 110, 110, 0, 1);
      add(1, 0, 9'h0AA, 200, 180, 1, 1);
      add(0, 0, 9'h123, 111, 100, 0, 0);
      add(1, 0, 9'h0F0, 221, 220, 1, 0);
      add(0, 0, 9'h00F, 100, 89, 0, 0);
      add(0, 0, 9'h111, 182, 182, 1, 1);
      add(1, 0, 9'h122, 100, 100, 0, 1);
      add(1, 0, 9'h133, 105, 95, 0, 0);
      add(0, 0, 9'h144, 0, 0, 2, 0);
      add(0, 0, 9'h155, 639, 479, 2, 0);
      add(0, 0, 9'h166, 320, 240, 2, 0);
      add(1, 0, 9'h177, 639, 479, 2, 0);
      add(1, 0, 9'h188, 320, 240, 2, 0);
      add(1, 0, 9'h199, 65, 65, 3, 1);
      add(1, 0, 9'h1AA, 65, 66, 3, 0);
      add(1, 0, 9'h1BB, 1023, 1023, 4, 1);
      add(1, 0, 9'h1CC, 600, 600, 4, 1);
      add(1, 0, 9'h1DD, 100, 100, 4, 0);
      add(1, 1, 9'h1EE, 200, 210, 1, 0);
      add(0, 0, 9'h1C7, 1023, 1023, 4, 1);

      // reset state
      reset = 1'b0;
      drive_pix(0, 1, 9'h000, 10'd0, 10'd0, 0);
      #12;
      chk("rst_hit", {31'd0, out_hit}, 32'd0);
      chk("rst_bubble", {31'd0, out_bubble}, 32'd1);
      chk("rst_color", {23'd0, out_color}, 32'd0);
      chk("rst_pixel", {12'd0, out_pixel_x, out_pixel_y}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // table streamed one pixel per cycle, checked three edges later
      for (int c = 0; c < nv + 2; c++) begin
         @(negedge clk);
         if (c < nv)
            drive_pix(vt[c].form, vt[c].bub, vt[c].col, vt[c].px, vt[c].py, vt[c].vs);
         else
            drive_pix(0, 1, 9'h000, 10'd0, 10'd0, 0);
         @(posedge clk);
         #1;
         if (c >= 2) begin
            int j;
            j = c - 2;
            chk($sformatf("v%0d_hit", j), {31'd0, out_hit}, {31'd0, vt[j].hit});
            chk($sformatf("v%0d_bubble", j), {31'd0, out_bubble}, {31'd0, vt[j].bub});
            chk($sformatf("v%0d_color", j), {23'd0, out_color}, {23'd0, vt[j].col});
            chk($sformatf("v%0d_pixel", j), {12'd0, out_pixel_x, out_pixel_y},
                {12'd0, vt[j].px, vt[j].py});
         end
      end

      // reset mid-stream with three hit pixels in flight
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive_pix(0, 0, 9'h101 + 9'(k), 10'd100, 10'd100, 0);
      end
      @(posedge clk);
      #1;
      chk("pre_rst_hit", {31'd0, out_hit}, 32'd1);
      chk("pre_rst_color", {23'd0, out_color}, 32'h101);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_hit", {31'd0, out_hit}, 32'd0);
      chk("mid_rst_bubble", {31'd0, out_bubble}, 32'd1);
      chk("mid_rst_color", {23'd0, out_color}, 32'd0);
      chk("mid_rst_pixel", {12'd0, out_pixel_x, out_pixel_y}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive_pix(0, 0, 9'h0AA, 10'd95, 10'd105, 0);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) drive_pix(0, 1, 9'h000, 10'd100, 10'd100, 0);
         if (e < 3) begin
            chk($sformatf("post_rst_e%0d_bubble", e), {31'd0, out_bubble}, 32'd1);
            chk($sformatf("post_rst_e%0d_hit", e), {31'd0, out_hit}, 32'd0);
         end else begin
            chk("post_rst_first_bubble", {31'd0, out_bubble}, 32'd0);
            chk("post_rst_first_hit", {31'd0, out_hit}, 32'd1);
            chk("post_rst_first_color", {23'd0, out_color}, 32'h0AA);
            chk("post_rst_first_pixel", {12'd0, out_pixel_x, out_pixel_y},
                {12'd0, 10'd95, 10'd105});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
